// File: rtl/led_breathe_multi.sv
// led_breathe_multi: multi-channel breathing-LED PWM from shared counters.
// Define LED_BREATHE_STAGGER_EN to build per-channel phase offsets (mode 11).
module led_breathe_multi #(
    parameter int LED_WIDTH = 8,
    parameter int TICK_DIV  = 50,
    parameter int PWM_STEPS = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    output logic [LED_WIDTH-1:0] led_data,
    output logic                 cycle_done
);

    localparam int PWM_W = $clog2(PWM_STEPS);
    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TW-1:0]    TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [PWM_W-1:0] STEP_MAX = PWM_W'(PWM_STEPS - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_STAGGER = 2'b11
    } mode_e;

    logic [TW-1:0]        tick_cnt;
    logic [PWM_W-1:0]     pwm_cnt;
    logic [PWM_W-1:0]     level;
    logic                 dir;
    mode_e                mode_q;

    logic                 tick;
    logic                 period_end;
    logic                 ramp_end;
    logic [LED_WIDTH-1:0] chan_on;
    logic [LED_WIDTH-1:0] led_next;

    assign tick       = en && (tick_cnt == TICK_MAX);
    assign period_end = tick && (pwm_cnt == STEP_MAX);
    assign ramp_end   = period_end && (level == STEP_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            pwm_cnt  <= '0;
            level    <= '0;
            dir      <= 1'b0;
            mode_q   <= MODE_OFF;
        end else if (en) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= (pwm_cnt == STEP_MAX) ? '0 : pwm_cnt + 1'b1;
            end
            // Mode only changes on a period boundary so no PWM period is cut short.
            if (period_end) begin
                mode_q <= mode_e'(mode);
                if (level == STEP_MAX) begin
                    level <= '0;
                    dir   <= ~dir;
                end else begin
                    level <= level + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < LED_WIDTH; i++) begin : g_ch
        logic [PWM_W-1:0] lvl_i;
        logic             dir_i;
`ifdef LED_BREATHE_STAGGER_EN
        localparam int             STAGGER = PWM_STEPS / LED_WIDTH;
        localparam logic [PWM_W:0] OFS     = (PWM_W + 1)'(i * STAGGER);
        localparam logic [PWM_W:0] STEPS_X = (PWM_W + 1)'(PWM_STEPS);

        logic [PWM_W:0] s;

        assign s = {1'b0, level} + OFS;

        // Overflowing the ramp lands the channel on the opposite slope.
        always_comb begin
            lvl_i = level;
            dir_i = dir;
            if (mode_q == MODE_STAGGER) begin
                if (s >= STEPS_X) begin
                    lvl_i = PWM_W'(s - STEPS_X);
                    dir_i = ~dir;
                end else begin
                    lvl_i = s[PWM_W-1:0];
                end
            end
        end
`else
        assign lvl_i = level;
        assign dir_i = dir;
`endif
        assign chan_on[i] = dir_i ? (pwm_cnt >= lvl_i) : (pwm_cnt < lvl_i);
    end

    always_comb begin
        led_next = '0;
        unique case (mode_q)
            MODE_OFF:     led_next = '0;
            MODE_ON:      led_next = '1;
            MODE_BREATHE: led_next = chan_on;
            MODE_STAGGER: led_next = chan_on;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_data   <= '0;
            cycle_done <= 1'b0;
        end else begin
            led_data   <= en ? led_next : '0;
            cycle_done <= ramp_end && dir;
        end
    end

endmodule

// File: tb/tb_led_breathe_multi.sv
// Bench for led_breathe_multi: directed stimulus, expectations queued to a
// monitor that checks them against recorded output history.
module tb_led_breathe_multi;

    localparam int LW   = 4;
    localparam int TD   = 2;
    localparam int PS   = 8;
    localparam int HMAX = 2048;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          en   = 1'b1;
    logic [1:0]    mode = 2'b01;
    logic [LW-1:0] led_data;
    logic          cycle_done;

    int pc    = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [LW-1:0] hist_led [HMAX];
    logic          hist_cd  [HMAX];

    typedef enum int {K_VAL, K_EQ, K_HI, K_CD} kind_e;

    typedef struct {
        string name;
        kind_e kind;
        int    ch;
        int    c0;
        int    c1;
        int    val;
        int    exp;
    } chk_t;

    chk_t sb[$];

    led_breathe_multi #(
        .LED_WIDTH (LW),
        .TICK_DIV  (TD),
        .PWM_STEPS (PS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .led_data   (led_data),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pc <= pc + 1;

    task automatic push(input string name, input kind_e kind, input int ch,
                        input int c0, input int c1, input int val,
                        input int exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.ch   = ch;
        c.c0   = c0;
        c.c1   = c1;
        c.val  = val;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    task automatic run_check(input chk_t c);
        int act;
        act = 0;
        for (int k = c.c0; k <= c.c1; k++) begin
            case (c.kind)
                K_VAL: act = int'(hist_led[k]);
                K_EQ:  if (hist_led[k] === LW'(c.val)) act++;
                K_HI:  if (hist_led[k][c.ch] === 1'b1) act++;
                K_CD:  if (hist_cd[k] === 1'b1) act++;
                default: act = -1;
            endcase
        end
        n_cmp++;
        if (act != c.exp) begin
            n_bad++;
            $display("FAIL %s ch%0d clk %0d..%0d: got %0d, want %0d",
                     c.name, c.ch, c.c0, c.c1, act, c.exp);
        end
    endtask

    // Monitor: record outputs each cycle, check entries whose window has closed.
    always @(negedge clk) begin
        if (pc < HMAX) begin
            hist_led[pc] = led_data;
            hist_cd[pc]  = cycle_done;
        end
        while (sb.size() > 0 && sb[0].c1 <= pc) begin
            run_check(sb.pop_front());
        end
    end

    task automatic wait_pc(input int p);
        while (pc < p) @(negedge clk);
    endtask

    int cd_at [4] = '{259, 515, 771, 1027};
    int stg   [4];

    initial begin
`ifdef LED_BREATHE_STAGGER_EN
        stg = '{0, 4, 8, 12};
`else
        stg = '{0, 0, 0, 0};
`endif
        push("rst_led", K_EQ, 0, 1, 3, 0, 3);
        push("rst_cd", K_CD, 0, 1, 19, 0, 0);
        push("first_period_off", K_EQ, 0, 4, 19, 0, 16);
        wait_pc(3);
        rst = 1'b0;

        push("on_until_boundary", K_EQ, 0, 20, 35, 15, 16);
        push("off_after_boundary", K_VAL, 0, 36, 36, 0, 0);
        push("off_period", K_EQ, 0, 36, 51, 0, 16);
        wait_pc(23);
        mode = 2'b00;
        wait_pc(40);
        mode = 2'b10;

        for (int c = 0; c < LW; c++) push("rise_l3_hi", K_HI, c, 52, 67, 0, 6);
        push("rise_l3_all", K_EQ, 0, 52, 67, 15, 6);
        for (int c = 0; c < LW; c++) push("fall_l3_hi", K_HI, c, 180, 195, 0, 10);
        push("fall_l3_all", K_EQ, 0, 180, 195, 15, 10);

        push("cd_total", K_CD, 0, 1, 1030, 0, 4);
        for (int k = 0; k < 4; k++) push("cd_pulse", K_CD, 0, cd_at[k], cd_at[k], 0, 1);
        for (int k = 0; k < 3; k++) push("cd_gap", K_CD, 0, cd_at[k] + 1, cd_at[k + 1] - 1, 0, 0);

        wait_pc(1015);
        mode = 2'b11;
        for (int c = 0; c < LW; c++) push("stagger_hi", K_HI, c, 1028, 1043, 0, stg[c]);
        wait_pc(1035);
        mode = 2'b10;

        push("pre_freeze", K_VAL, 0, 1061, 1061, 0, 15);
        push("freeze_zero", K_EQ, 0, 1062, 1101, 0, 40);
        push("freeze_cd", K_CD, 0, 1062, 1101, 0, 0);
        for (int c = 0; c < LW; c++) push("resume_hi", K_HI, c, 1060, 1115, 0, 4);
        push("cd_quiet", K_CD, 0, 1028, 1322, 0, 0);
        push("cd_shifted", K_CD, 0, 1323, 1323, 0, 1);
        wait_pc(1061);
        en = 1'b0;
        wait_pc(1101);
        en = 1'b1;

        wait_pc(1330);
        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        n_cmp++;
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d checks pending, want 0", sb.size());
            n_bad++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
